fnd_controller: RTL and testbench

FND_CONTROLLER -- requirements
Module: fnd_controller

---
 rtl/fnd_pkg.sv | 35 +++
 rtl/fnd_if.sv | 22 ++
 rtl/fnd_font_decoder.sv | 26 ++
 rtl/fnd_controller.sv | 84 ++++++++
 tb/tb_fnd_controller.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit seven-segment (FND) scanner.
package fnd_pkg;

    localparam int DIGIT_NUM = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}, dp off
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_DASH  = 8'hBF;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    typedef struct packed {
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic       mode;
    } snap_t;

    // Units (tens=0) or tens (tens=1) digit of a field already known to be 0..99
    function automatic logic [3:0] digit_of(input logic [6:0] field, input logic tens);
        return tens ? 4'(field / 7'd10) : 4'(field % 7'd10);
    endfunction

endpackage

// File: rtl/fnd_if.sv
// Time-field inputs and FND drive outputs of the display scanner.
interface fnd_if;

    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       mode;
    logic [3:0] fnd_comm;
    logic [7:0] fnd_font;

    modport master (
        output msec, sec, min, hour, mode,
        input  fnd_comm, fnd_font
    );

    modport slave (
        input  msec, sec, min, hour, mode,
        output fnd_comm, fnd_font
    );

endinterface

// File: rtl/fnd_font_decoder.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder.
module fnd_font_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = FONT_BLANK[6:0];
        case (value)
            4'd0:    seg = FONT_0[6:0];
            4'd1:    seg = FONT_1[6:0];
            4'd2:    seg = FONT_2[6:0];
            4'd3:    seg = FONT_3[6:0];
            4'd4:    seg = FONT_4[6:0];
            4'd5:    seg = FONT_5[6:0];
            4'd6:    seg = FONT_6[6:0];
            4'd7:    seg = FONT_7[6:0];
            4'd8:    seg = FONT_8[6:0];
            4'd9:    seg = FONT_9[6:0];
            default: seg = FONT_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/fnd_controller.sv
// 4-digit multiplexed FND driver showing sec.msec or hour.min from a per-frame snapshot.
// Define FND_DOT_BLINK_EN to light the digit-2 dot only while the frame's msec < 50.
module fnd_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    fnd_if.slave bus
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]     div_q, div_d;
    digit_idx_t           idx_q, idx_d;
    snap_t                snap_q, snap_d;
    logic [DIGIT_NUM-1:0] comm_q, comm_d;
    logic [7:0]           font_q, font_d;

    logic       tick;
    logic       capture;
    snap_t      live;
    snap_t      src;
    logic [6:0] low;
    logic [6:0] high;
    logic [6:0] field;
    logic [3:0] digit;
    logic [6:0] seg;
    logic       dp_on;

    fnd_font_decoder u_font_decoder (
        .value (digit),
        .seg   (seg)
    );

    always_comb begin
        live    = {bus.msec, bus.sec, bus.min, bus.hour, bus.mode};
        tick    = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        capture = tick && (idx_q == 2'd3);
        snap_d  = capture ? live : snap_q;

        // Digit 0 of a new frame is shown from the very sample being captured
        src   = capture ? live : snap_q;
        low   = src.mode ? {1'b0, src.min}  : src.msec;
        high  = src.mode ? {2'b0, src.hour} : {1'b0, src.sec};
        field = idx_d[1] ? high : low;
        digit = digit_of(field, idx_d[0]);

        dp_on = (idx_d == 2'd2);
`ifdef FND_DOT_BLINK_EN
        dp_on = dp_on && (src.msec < 7'd50);
`endif

        comm_d = comm_q;
        font_d = font_q;
        if (tick) begin
            comm_d = ~(DIGIT_NUM'(1) << idx_d);
            font_d = {~dp_on, (field > 7'd99) ? FONT_DASH[6:0] : seg};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            comm_q <= '1;
            font_q <= FONT_BLANK;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            comm_q <= comm_d;
            font_q <= font_d;
        end
    end

    assign bus.fnd_comm = comm_q;
    assign bus.fnd_font = font_q;

endmodule

// File: tb/tb_fnd_controller.sv
// Self-checking bench for fnd_controller: directed frame checks plus a frame-level scoreboard.
module tb_fnd_controller;

    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic reset;

    fnd_if bus ();

    fnd_controller #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [11:0] sb_q [$];
    int          m_div = 0;
    int          m_idx = 0;
    logic [31:0] m_frame;
    logic [3:0]  m_comm;
    logic [11:0] sb_e;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] code(input int v, input bit tens);
        int d;
        d = tens ? v / 10 : v % 10;
        if (v > 99) return 8'hBF;
        return font_tab[d];
    endfunction

    // Whole frame {d3,d2,d1,d0} for one captured sample
    function automatic logic [31:0] make_frame(input int ms, input int s, input int mi,
                                               input int h, input bit md);
        int lo, hi;
        logic [7:0] d2;
        lo = md ? mi : ms;
        hi = md ? h : s;
        d2 = code(hi, 1'b0);
`ifdef FND_DOT_BLINK_EN
        if (ms < 50) d2[7] = 1'b0;
`else
        d2[7] = 1'b0;
`endif
        return {code(hi, 1'b1), d2, code(lo, 1'b1), code(lo, 1'b0)};
    endfunction

    // Reference scanner: pushes the expected outputs for every tick edge
    always @(posedge clk) begin
        if (!reset) begin
            m_div   = 0;
            m_idx   = 0;
            m_frame = make_frame(0, 0, 0, 0, 1'b0);
            sb_q.delete();
        end else if (m_div == SCAN_DIV - 1) begin
            m_div = 0;
            if (m_idx == 3)
                m_frame = make_frame(int'(bus.msec), int'(bus.sec), int'(bus.min),
                                     int'(bus.hour), bus.mode);
            m_idx  = (m_idx + 1) % 4;
            m_comm = 4'b1111 ^ (4'b0001 << m_idx);
            sb_q.push_back({m_comm, m_frame[m_idx*8 +: 8]});
        end else begin
            m_div++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check_val("sb_comm", {28'b0, bus.fnd_comm}, {28'b0, sb_e[11:8]});
            check_val("sb_font", {24'b0, bus.fnd_font}, {24'b0, sb_e[7:0]});
        end
    end

    task automatic drive(input int ms, input int s, input int mi, input int h, input bit md);
        @(negedge clk);
        bus.msec = 7'(ms);
        bus.sec  = 6'(s);
        bus.min  = 6'(mi);
        bus.hour = 5'(h);
        bus.mode = md;
    endtask

    // Returns at the first negedge where digit idx newly becomes active
    task automatic wait_digit(input int idx, input string tag);
        logic [3:0] want;
        logic [3:0] prev;
        bit         seen;
        seen = 1'b0;
        want = 4'b1111 ^ (4'b0001 << idx);
        @(negedge clk);
        prev = bus.fnd_comm;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (bus.fnd_comm == want && prev != want) seen = 1'b1;
            prev = bus.fnd_comm;
        end
        check_val({tag, "_seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic expect_font(input int idx, input string tag, input logic [7:0] exp);
        wait_digit(idx, tag);
        check_val(tag, {24'b0, bus.fnd_font}, {24'b0, exp});
    endtask

    task automatic reset_release_check(input string tag);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < SCAN_DIV - 1; i++) begin
            @(posedge clk);
            #1;
            check_val({tag, "_hold_comm"}, {28'b0, bus.fnd_comm}, 32'hF);
        end
        @(posedge clk);
        #1;
        check_val({tag, "_tick_comm"}, {28'b0, bus.fnd_comm}, 32'b1101);
        check_val({tag, "_tick_font"}, {24'b0, bus.fnd_font}, 32'hC0);
    endtask

    initial begin
        reset    = 1'b0;
        bus.msec = '0;
        bus.sec  = '0;
        bus.min  = '0;
        bus.hour = '0;
        bus.mode = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_comm", {28'b0, bus.fnd_comm}, 32'hF);
        check_val("rst_font", {24'b0, bus.fnd_font}, 32'hFF);
        reset_release_check("release");

        drive(34, 12, 0, 0, 1'b0);
        expect_font(0, "m0_d0", 8'h99);
        expect_font(1, "m0_d1", 8'hB0);
        expect_font(2, "m0_d2", 8'h24);
        expect_font(3, "m0_d3", 8'hF9);

        drive(70, 0, 5, 23, 1'b1);
        expect_font(0, "m1_d0", 8'h92);
        expect_font(1, "m1_d1", 8'hC0);
`ifdef FND_DOT_BLINK_EN
        expect_font(2, "m1_d2", 8'hB0);
`else
        expect_font(2, "m1_d2", 8'h30);
`endif
        expect_font(3, "m1_d3", 8'hA4);

        drive(120, 12, 0, 0, 1'b0);
        expect_font(0, "dash_d0", 8'hBF);
        expect_font(1, "dash_d1", 8'hBF);

        drive(49, 12, 0, 0, 1'b0);
        wait_digit(0, "dp49_frame");
        wait_digit(2, "dp49");
        check_val("dp49_bit7", {31'b0, bus.fnd_font[7]}, 32'd0);
        drive(50, 12, 0, 0, 1'b0);
        wait_digit(0, "dp50_frame");
        wait_digit(2, "dp50");
`ifdef FND_DOT_BLINK_EN
        check_val("dp50_bit7", {31'b0, bus.fnd_font[7]}, 32'd1);
`else
        check_val("dp50_bit7", {31'b0, bus.fnd_font[7]}, 32'd0);
`endif

        // Field change in the middle of a frame must not tear the display
        drive(34, 12, 0, 0, 1'b0);
        wait_digit(0, "tear_start");
        wait_digit(1, "tear_d1");
        bus.sec  = 6'd13;
        bus.mode = 1'b1;
        expect_font(2, "tear_old_d2", 8'h24);
        expect_font(3, "tear_old_d3", 8'hF9);
        bus.mode = 1'b0;
        expect_font(0, "tear_new_d0", 8'h99);
        expect_font(2, "tear_new_d2", 8'h30);
        expect_font(3, "tear_new_d3", 8'hF9);

        // Reset pulse mid-frame
        wait_digit(2, "midrst_d2");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_comm", {28'b0, bus.fnd_comm}, 32'hF);
        check_val("midrst_font", {24'b0, bus.fnd_font}, 32'hFF);
        reset_release_check("midrst");

        for (int k = 0; k < 40; k++) begin
            drive($urandom_range(0, 127), $urandom_range(0, 63), $urandom_range(0, 63),
                  $urandom_range(0, 31), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 20)) @(posedge clk);
        end
        repeat (2 * 4 * SCAN_DIV) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
